// File: rtl/xulie_det_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xulie_pkg
// Description : Shared types and default sizes for the serial sequence
//               detector (FSM state encoding, default pattern/counter widths).
// Revision    : 1.0 - initial release
// ============================================================================
package xulie_pkg;

    localparam int PAT_W_DEF = 4;   // default pattern length in bits
    localparam int CNT_W_DEF = 8;   // default frame-length / hit counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : xulie_pkg
`default_nettype wire

// File: rtl/xulie_det_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : xulie_det_ctrl_if
// Description : Control/data bundle of the sequence detector.
//               master : frame requester / data source (drives start..din)
//               slave  : detector (drives busy, hit, done, hit_count)
// Revision    : 1.0 - initial release
// ============================================================================
interface xulie_det_ctrl_if
    import xulie_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] frame_len;
    logic             overlap_en;
    logic             din_valid;
    logic             din;
    logic             busy;
    logic             hit;
    logic             done;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output start, abort, pattern, frame_len, overlap_en, din_valid, din,
        input  busy, hit, done, hit_count
    );

    modport slave (
        input  start, abort, pattern, frame_len, overlap_en, din_valid, din,
        output busy, hit, done, hit_count
    );

endinterface : xulie_det_ctrl_if
`default_nettype wire

// File: rtl/xulie_det_ctrl_shift_match.sv
`default_nettype none
// ============================================================================
// Module      : xulie_shift_match
// Description : Serial shift register, saturating fill counter and pattern
//               comparator. o_match is combinational and reflects the state
//               after the bit presented this cycle is shifted in.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               i_clr           - clear shift register and fill count
//               i_shift         - accept i_din this cycle
//               i_din           - serial bit, enters at the LSB
//               i_overlap       - 1: keep fill count on match, 0: clear it
//               i_pattern       - latched target pattern (MSB = oldest bit)
//               o_match         - match on the bit accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module xulie_shift_match
    import xulie_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_clr,
    input  wire logic             i_shift,
    input  wire logic             i_din,
    input  wire logic             i_overlap,
    input  wire logic [PAT_W-1:0] i_pattern,
    output logic                  o_match
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  r_shreg;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  w_shreg_nxt;
    logic [FILL_W-1:0] w_fill_nxt;

    always_comb begin
        w_shreg_nxt = {r_shreg[PAT_W-2:0], i_din};
        w_fill_nxt  = (r_fill == c_fill_full) ? r_fill : r_fill + 1'b1;
        // Only a full window of fresh bits may match; the fill count is what
        // prevents stale or cleared bits from forming a false match.
        o_match     = i_shift && (w_fill_nxt == c_fill_full) &&
                      (w_shreg_nxt == i_pattern);
    end

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_shreg <= '0;
            r_fill  <= '0;
        end else if (i_shift) begin
            r_shreg <= w_shreg_nxt;
            // Non-overlapping mode: the matched bits are consumed.
            r_fill  <= (o_match && !i_overlap) ? '0 : w_fill_nxt;
        end
    end

endmodule : xulie_shift_match
`default_nettype wire

// File: rtl/xulie_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xulie_det_ctrl
// Description : Framed serial sequence detector. A frame of frame_len valid
//               bits is scanned for a PAT_W-bit pattern; each match gives a
//               one-cycle hit pulse and bumps a saturating hit counter.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               bus (slave)     - start/abort/pattern/frame_len/overlap_en/
//                                 din_valid/din in; busy/hit/done/hit_count out
// Revision    : 1.0 - initial release
// ============================================================================
module xulie_det_ctrl
    import xulie_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  wire logic        clk,
    input  wire logic        reset,
    xulie_det_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAT_W-1:0] r_pattern;
    logic [CNT_W-1:0] r_frame_len;
    logic             r_overlap;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_hit_cnt;
    logic             r_hit;

    logic             w_start_ok;
    logic             w_accept;
    logic             w_last;
    logic             w_match;

    // Abort suppresses the bit entirely, so it can neither match nor finish.
    always_comb begin
        w_start_ok  = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                w_start_ok = bus.start && (bus.frame_len != '0);
                if (w_start_ok)
                    w_state_nxt = RUN;
            end
            RUN: begin
                w_accept = bus.din_valid && !bus.abort;
                w_last   = w_accept && ((r_bit_cnt + 1'b1) == r_frame_len);
                if (bus.abort)
                    w_state_nxt = IDLE;
                else if (w_last)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern   <= '0;
            r_frame_len <= '0;
            r_overlap   <= 1'b0;
            r_bit_cnt   <= '0;
            r_hit_cnt   <= '0;
            r_hit       <= 1'b0;
        end else begin
            r_hit <= w_match;
            if (w_start_ok) begin
                r_pattern   <= bus.pattern;
                r_frame_len <= bus.frame_len;
                r_overlap   <= bus.overlap_en;
                r_bit_cnt   <= '0;
                r_hit_cnt   <= '0;
            end else if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_match && (r_hit_cnt != c_cnt_max))
                    r_hit_cnt <= r_hit_cnt + 1'b1;
            end
        end
    end

    xulie_shift_match #(
        .PAT_W (PAT_W)
    ) u_shift_match (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_start_ok),
        .i_shift   (w_accept),
        .i_din     (bus.din),
        .i_overlap (r_overlap),
        .i_pattern (r_pattern),
        .o_match   (w_match)
    );

    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.hit       = r_hit;
    assign bus.hit_count = r_hit_cnt;

endmodule : xulie_det_ctrl
`default_nettype wire

// File: tb/tb_xulie_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_xulie_det_ctrl
// Description : Directed self-checking bench for xulie_det_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xulie_det_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    xulie_det_ctrl_if #(.PAT_W(4), .CNT_W(8)) bus ();

    xulie_det_ctrl #(
        .PAT_W (4),
        .CNT_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // bits/hmask: bit number k (1-based) of the frame sits at index 16-k.
    task automatic run_frame(input string tag, input logic [3:0] pat, input logic ovl,
                             input int n, input logic [15:0] bits, input logic [15:0] hmask,
                             input int gap, input int abort_at, input int start_at,
                             input int exp_cnt);
        bus.pattern    = pat;
        bus.frame_len  = 8'(n);
        bus.overlap_en = ovl;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        chk({tag, "_cnt_clr"}, 32'(bus.hit_count), 32'd0);
        // Frame settings are latched; scrambling them must not matter.
        bus.pattern    = ~pat;
        bus.frame_len  = 8'd3;
        bus.overlap_en = ~ovl;
        for (int i = 1; i <= n; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.din_valid = 1'b0;
                step();
                chk($sformatf("%s_gap_busy%0d", tag, i), 32'(bus.busy), 32'd1);
                chk($sformatf("%s_gap_hit%0d", tag, i), 32'(bus.hit), 32'd0);
            end
            bus.din_valid = 1'b1;
            bus.din       = bits[16-i];
            bus.abort     = (i == abort_at);
            bus.start     = (i == start_at);
            step();
            bus.din_valid = 1'b0;
            bus.abort     = 1'b0;
            bus.start     = 1'b0;
            if (i == abort_at) begin
                chk({tag, "_abort_hit"}, 32'(bus.hit), 32'd0);
                chk({tag, "_abort_busy"}, 32'(bus.busy), 32'd0);
                chk({tag, "_abort_done"}, 32'(bus.done), 32'd0);
                chk({tag, "_abort_cnt"}, 32'(bus.hit_count), 32'(exp_cnt));
                step();
                chk({tag, "_abort_done2"}, 32'(bus.done), 32'd0);
                chk({tag, "_abort_idle"}, 32'(bus.busy), 32'd0);
                return;
            end
            chk($sformatf("%s_hit%0d", tag, i), 32'(bus.hit), 32'(hmask[16-i]));
            chk($sformatf("%s_done%0d", tag, i), 32'(bus.done), 32'(i == n));
        end
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        chk({tag, "_cnt"}, 32'(bus.hit_count), 32'(exp_cnt));
        step();
        chk({tag, "_done_off"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_cnt_hold"}, 32'(bus.hit_count), 32'(exp_cnt));
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pattern    = 4'd0;
        bus.frame_len  = 8'd0;
        bus.overlap_en = 1'b0;
        bus.din_valid  = 1'b0;
        bus.din        = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hit", 32'(bus.hit), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cnt", 32'(bus.hit_count), 32'd0);
        reset = 1'b0;

        // Stream 0101101101100100 = 16'h5B64, pattern 0110.
        run_frame("ovl",   4'b0110, 1'b1, 16, 16'h5B64, 16'h0490, 0, 0, 0, 3);
        run_frame("novl",  4'b0110, 1'b0, 16, 16'h5B64, 16'h0410, 0, 0, 0, 2);
        run_frame("ones1", 4'b1111, 1'b1, 6,  16'hFC00, 16'h1C00, 0, 0, 0, 3);
        run_frame("ones0", 4'b1111, 1'b0, 6,  16'hFC00, 16'h1000, 0, 0, 0, 1);
        run_frame("gaps",  4'b0110, 1'b1, 16, 16'h5B64, 16'h0490, 2, 0, 0, 3);
        run_frame("abort", 4'b0110, 1'b1, 16, 16'h5B64, 16'h0490, 0, 12, 0, 2);
        // Start during RUN (at bit 6) must not restart the frame.
        run_frame("stbusy", 4'b1111, 1'b1, 8, 16'hFF00, 16'h1F00, 0, 0, 6, 5);

        // Reset mid-frame with start/din_valid asserted at the same edge.
        bus.pattern    = 4'b0110;
        bus.frame_len  = 8'd16;
        bus.overlap_en = 1'b1;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = (i == 2 || i == 4 || i == 5);
            step();
        end
        chk("pre_rst_hit", 32'(bus.hit), 32'd1);
        reset     = 1'b1;
        bus.start = 1'b1;
        step();
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_hit", 32'(bus.hit), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_cnt", 32'(bus.hit_count), 32'd0);
        reset         = 1'b0;
        bus.din_valid = 1'b0;
        bus.frame_len = 8'd0;
        step();
        bus.start = 1'b0;
        chk("len0_busy", 32'(bus.busy), 32'd0);
        step();
        chk("len0_busy2", 32'(bus.busy), 32'd0);
        chk("len0_done", 32'(bus.done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_xulie_det_ctrl
`default_nettype wire

// File: doc/xulie_det_ctrl.md
XULIE_DET_CTRL -- requirements
Module: xulie_det_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (2..8).
REQ-002 SHALL have parameter CNT_W, default 8, width of frame-length and hit counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a detection frame.
REQ-006 SHALL have port abort  input  1  terminate the current frame with no done pulse.
REQ-007 SHALL have port pattern  input  PAT_W  target sequence; MSB is the first bit received.
REQ-008 SHALL have port frame_len  input  CNT_W  number of valid bits in the frame.
REQ-009 SHALL have port overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-010 SHALL have port din_valid  input  1  din is valid this cycle.
REQ-011 SHALL have port din  input  1  serial data bit.
REQ-012 SHALL have port busy  output  1  high in RUN.
REQ-013 SHALL have port hit  output  1  registered Moore match pulse.
REQ-014 SHALL have port done  output  1  one-cycle frame-complete pulse.
REQ-015 SHALL have port hit_count  output  CNT_W  matches counted in the current or last frame.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE: start=1 with frame_len!=0 SHALL latch pattern, frame_len and overlap_en, clear the shift register, fill count, bit count and hit_count, and enter RUN next cycle.
REQ-018 IDLE: start with frame_len==0 SHALL be ignored; din_valid SHALL be ignored.
REQ-019 RUN: each din_valid=1 cycle SHALL shift din in at the LSB, increment the bit count, and increment the fill count (saturating at PAT_W).
REQ-020 A match SHALL occur when, after the shift, fill count == PAT_W and the shift register equals the latched pattern.
REQ-021 hit SHALL assert exactly one cycle after the clock edge that accepts the matching bit, for one cycle; latency 1.
REQ-022 On a match with overlap_en latched 0, fill count SHALL clear to 0; with overlap_en latched 1, fill count SHALL be unaffected.
REQ-023 hit_count SHALL increment on each match and saturate at 2^CNT_W-1.
REQ-024 When the accepted bit makes bit count equal frame_len, the FSM SHALL enter DONE; a match on that bit SHALL still be counted and pulsed.
REQ-025 DONE SHALL last one cycle with done=1 and then return to IDLE; hit_count SHALL hold until the next accepted start.
REQ-026 start while busy or in DONE SHALL be ignored; inputs changing mid-frame SHALL have no effect, because they are latched.
REQ-027 abort in RUN SHALL return to IDLE next cycle with no done pulse, hit_count held and no hit for that cycle's bit; abort SHALL win over a simultaneous last bit.
REQ-028 din_valid=0 cycles in RUN SHALL stall the frame with no state change.

Reset
REQ-029 On reset=1 at a clock edge: state IDLE, busy=0, hit=0, done=0, hit_count=0, and all internal registers 0.
REQ-030 reset SHALL override start, abort and din_valid in the same cycle, including mid-frame.

Structure
REQ-031 Package xulie_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default PAT_W/CNT_W constants.
REQ-032 Sub-module xulie_shift_match SHALL contain the shift register, fill counter and comparator, and output a combinational match; the FSM and counters SHALL stay in xulie_det_ctrl.

Verification
REQ-033 pattern=0110, overlap_en=1, frame_len=16, stream 0,1,0,1,1,0,1,1,0,1,1,0,0,1,0,0 -> hit one cycle after bits 6, 9 and 12; done after bit 16; hit_count=3.
REQ-034 Same stream, overlap_en=0 -> hits after bits 6 and 12 only; hit_count=2.
REQ-035 pattern=1111, frame_len=6, six 1s: overlap_en=1 -> hit_count=3; overlap_en=0 -> hit_count=1.
REQ-036 Gaps: insert din_valid=0 cycles between bits of the REQ-033 stream -> identical hit sequence and hit_count=3; busy held throughout.
REQ-037 abort on bit 12 of the REQ-033 stream -> no hit for bit 12, no done, hit_count=2, IDLE next cycle; a later start clears hit_count to 0.
REQ-038 reset mid-frame, then start with frame_len=0, then start during RUN -> all outputs 0 after reset, both starts ignored.
